// File: rtl/pwm_bank_if.sv
// rtl/pwm_bank_if.sv - single-beat valid/ready configuration write port for pwm_bank
interface pwm_bank_if #(
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM with shared prescaled timebase and period-wrap shadow commit
module pwm_bank #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 3,
    localparam int ADDR_W    = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    pwm_bank_if.slave           wr,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                wrap
);

    logic                  run;
    logic [PRESCALE_W-1:0] psc;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      period_sh;
    logic [WIDTH-1:0]      period_act;
    logic [WIDTH-1:0]      duty_sh  [CHANNELS];
    logic [WIDTH-1:0]      duty_act [CHANNELS];

    logic accept;
    logic tick;
    logic load;
    logic commit;

    assign tick   = ena && run && (presc_cnt == psc);
    assign load   = tick && (count == period_act);
    // Holding off writes during the load cycle keeps a shadow update from racing the copy.
    assign wr.wr_ready = !load;
    assign accept = wr.wr_valid && wr.wr_ready;
    // While stopped the active set follows the shadows so a start uses the latest values.
    assign commit = ena && (!run || load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            psc       <= '0;
            period_sh <= '0;
        end else if (accept) begin
            if (wr.wr_addr == ADDR_W'(0)) begin
                run <= wr.wr_data[WIDTH-1];
                psc <= wr.wr_data[PRESCALE_W-1:0];
            end
            if (wr.wr_addr == ADDR_W'(1)) begin
                period_sh <= wr.wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr.wr_addr == ADDR_W'(i + 2)) begin
                    duty_sh[i] <= wr.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            count     <= '0;
        end else if (!run) begin
            presc_cnt <= '0;
            count     <= '0;
        end else if (ena) begin
            presc_cnt <= (presc_cnt == psc) ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                count <= load ? '0 : count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= '0;
            end
        end else if (commit) begin
            period_act <= period_sh;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= duty_sh[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
            wrap    <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= ena && run && (count < duty_act[i]);
            end
            wrap <= load;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - self-checking bench for pwm_bank with a per-period scoreboard
module tb_pwm_bank;
    localparam int CHANNELS   = 4;
    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 3;
    localparam int ADDR_W     = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ena = 1'b0;
    logic [CHANNELS-1:0] pwm_out;
    logic                wrap;

    pwm_bank_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) wr_if ();

    pwm_bank #(
        .CHANNELS(CHANNELS),
        .WIDTH(WIDTH),
        .PRESCALE_W(PRESCALE_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .wr(wr_if),
        .pwm_out(pwm_out),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Expected shape of one wrap-to-wrap window: length and high cycles of channels 0..2.
    typedef struct {
        int len;
        int h0;
        int h1;
        int h2;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cnt = 0, h0 = 0, h1 = 0, h2 = 0;
    bit   have_prev = 1'b0;
    int   arm_req = 0, arm_seen = 0;
    bit   prev_rdy;

    always @(negedge clk) begin
        if (arm_req != arm_seen) begin
            arm_seen  = arm_req;
            have_prev = 1'b0;
        end
        if (wrap) begin
            if (have_prev && sb.size() > 0) begin
                e = sb.pop_front();
                check("period_len", cnt, e.len);
                check("high_ch0", h0, e.h0);
                check("high_ch1", h1, e.h1);
                check("high_ch2", h2, e.h2);
            end
            have_prev = 1'b1;
            cnt = 1;
            h0  = int'(pwm_out[0]);
            h1  = int'(pwm_out[1]);
            h2  = int'(pwm_out[2]);
        end else begin
            cnt++;
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
        end
    end

    task automatic push_exp(input int len, input int e0, input int e1, input int e2);
        exp_t x;
        x.len = len;
        x.h0  = e0;
        x.h1  = e1;
        x.h2  = e2;
        sb.push_back(x);
    endtask

    task automatic wr_beat(input int addr, input int data);
        int guard = 0;
        @(negedge clk);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = ADDR_W'(addr);
        wr_if.wr_data  = WIDTH'(data);
        while (!wr_if.wr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("wr_accept", 0, 1);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (sb.size() > 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_wrap();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!wrap && g < 100);
        if (!wrap) check("wrap_seen", 0, 1);
    endtask

    initial begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = 8'h80;
        ena   = 1'b1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_pwm", int'(pwm_out), 0);
            check("rst_wrap", int'(wrap), 0);
            check("rst_ready", int'(wr_if.wr_ready), 1);
        end
        wr_if.wr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_pwm", int'(pwm_out), 0);
            check("post_rst_wrap", int'(wrap), 0);
        end

        // basic: period 9, duties 3 / 0 / 10
        wr_beat(1, 9);
        wr_beat(2, 3);
        wr_beat(3, 0);
        wr_beat(4, 10);
        arm_req++;
        repeat (3) push_exp(10, 3, 0, 10);
        wr_beat(0, 'h80);
        check("start_pwm_t1", int'(pwm_out[0]), 0);
        @(negedge clk);
        check("start_pwm_t2", int'(pwm_out[0]), 1);
        drain("basic_drain");

        prev_rdy = wr_if.wr_ready;
        repeat (25) begin
            @(negedge clk);
            check("ready_vs_wrap", int'(wrap), int'(!prev_rdy));
            prev_rdy = wr_if.wr_ready;
        end

        // shadowing: mid-period duty change only shows after the next wrap
        wait_wrap();
        @(negedge clk);
        push_exp(10, 3, 0, 10);
        push_exp(10, 7, 0, 10);
        repeat (2) @(negedge clk);
        wr_beat(2, 7);
        drain("shadow_drain");

        // freeze: ena low for 5 cycles in the low part of the period
        wait_wrap();
        @(negedge clk);
        push_exp(15, 7, 0, 10);
        repeat (7) @(negedge clk);
        ena = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("frz_pwm", int'(pwm_out), 0);
            check("frz_wrap", int'(wrap), 0);
        end
        ena = 1'b1;
        drain("freeze_drain");

        // prescale: P=2, period 3, duty0 2
        wr_beat(0, 0);
        wr_beat(1, 3);
        wr_beat(2, 2);
        arm_req++;
        repeat (2) push_exp(12, 6, 0, 12);
        wr_beat(0, 'h82);
        drain("prescale_drain");

        // boundary: period 0, duty0 1, out-of-range address ignored
        wr_beat(0, 0);
        wr_beat(1, 0);
        wr_beat(2, 1);
        wr_beat(7, 'hFF);
        wr_beat(0, 'h80);
        @(negedge clk);
        repeat (8) begin
            check("bnd_pwm", int'(pwm_out), 'b0101);
            check("bnd_wrap", int'(wrap), 1);
            check("bnd_ready", int'(wr_if.wr_ready), 0);
            @(negedge clk);
        end

        rst_n = 1'b0;
        #1;
        check("midrst_pwm", int'(pwm_out), 0);
        check("midrst_wrap", int'(wrap), 0);
        check("midrst_ready", int'(wr_if.wr_ready), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
